// File: rtl/shared_alu_arbiter.sv
// shared_alu_arbiter: round-robin arbiter that lets NumReq requesters share a
// single external ALUdec+ALU pair. One operation is in flight at a time:
// IDLE (select/accept) -> EXEC (capture ALU result) -> RESP (hold until consumed).
module shared_alu_arbiter #(
  parameter int NumReq = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NumReq-1:0]      req_valid,
  output logic [NumReq-1:0]      req_ready,
  input  logic [6*NumReq-1:0]    req_opcode,
  input  logic [6*NumReq-1:0]    req_funct,
  input  logic [32*NumReq-1:0]   req_A,
  input  logic [32*NumReq-1:0]   req_B,
  output logic [NumReq-1:0]      resp_valid,
  input  logic [NumReq-1:0]      resp_ready,
  output logic [31:0]            resp_data,
  output logic [5:0]             alu_opcode,
  output logic [5:0]             alu_funct,
  output logic [31:0]            alu_A,
  output logic [31:0]            alu_B,
  input  logic [31:0]            alu_Out,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned NR = NumReq;

  logic [1:0]  r_state;
  logic [2:0]  r_rr_ptr;
  logic [2:0]  r_grant_id;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [31:0] r_A;
  logic [31:0] r_B;
  logic [31:0] r_result;

  logic [7:0]  w_valid8;
  logic [7:0]  w_rresp8;
  logic [3:0]  w_idx;
  logic        w_found;
  logic [2:0]  w_winner;
  logic [5:0]  w_sel_opcode;
  logic [5:0]  w_sel_funct;
  logic [31:0] w_sel_A;
  logic [31:0] w_sel_B;
  logic        w_accept;
  logic        w_done;

  // Widen the per-requester vectors to 8 bits so a 3-bit index always fits exactly
  always_comb begin
    w_valid8 = '0;
    w_rresp8 = '0;
    w_valid8[NumReq-1:0] = req_valid;
    w_rresp8[NumReq-1:0] = resp_ready;
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo NumReq
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_idx = {1'b0, r_rr_ptr} + 4'(k);
      if (w_idx >= 4'(NR)) begin
        w_idx = w_idx - 4'(NR);
      end
      if (!w_found && w_valid8[w_idx[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  // Operand mux selecting the winner's request fields for latching
  always_comb begin
    w_sel_opcode = '0;
    w_sel_funct  = '0;
    w_sel_A      = '0;
    w_sel_B      = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_opcode = req_opcode[6*i +: 6];
        w_sel_funct  = req_funct[6*i +: 6];
        w_sel_A      = req_A[32*i +: 32];
        w_sel_B      = req_B[32*i +: 32];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !Reset;
  assign w_done   = (r_state == S_RESP) && w_rresp8[r_grant_id];

  // One-hot handshake strobes; reset forces both low even before the state clears
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      req_ready[i]  = w_accept && (w_winner == 3'(i));
      resp_valid[i] = (r_state == S_RESP) && !Reset && (r_grant_id == 3'(i));
    end
  end

  assign busy       = (r_state != S_IDLE) && !Reset;
  assign grant_id   = r_grant_id;
  assign resp_data  = r_result;
  assign alu_opcode = r_opcode;
  assign alu_funct  = r_funct;
  assign alu_A      = r_A;
  assign alu_B      = r_B;

  // Arbitration FSM with operand/result registers; registers hold between operations
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_opcode   <= '0;
      r_funct    <= '0;
      r_A        <= '0;
      r_B        <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_opcode   <= w_sel_opcode;
            r_funct    <= w_sel_funct;
            r_A        <= w_sel_A;
            r_B        <= w_sel_B;
            r_grant_id <= w_winner;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= alu_Out;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (w_done) begin
            r_rr_ptr <= (r_grant_id == 3'(NR - 1)) ? '0 : r_grant_id + 3'd1;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_alu_arbiter.sv
// Testbench for shared_alu_arbiter: directed vectors with literal expectations
// plus a transaction-level model compared against the DUT on every cycle.
module tb_shared_alu_arbiter;

  localparam int N = 4;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [6*N-1:0]  req_opcode;
  logic [6*N-1:0]  req_funct;
  logic [32*N-1:0] req_A;
  logic [32*N-1:0] req_B;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [31:0]     resp_data;
  logic [5:0]      alu_opcode;
  logic [5:0]      alu_funct;
  logic [31:0]     alu_A;
  logic [31:0]     alu_B;
  logic [31:0]     alu_Out;
  logic            busy;
  logic [2:0]      grant_id;

  int total = 0;
  int bad   = 0;

  shared_alu_arbiter #(.NumReq(N)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct  (req_funct),
    .req_A      (req_A),
    .req_B      (req_B),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .alu_opcode (alu_opcode),
    .alu_funct  (alu_funct),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Out    (alu_Out),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 Clock = ~Clock;

  // Stand-in for the external ALUdec+ALU pair (purely combinational)
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 6'd0) begin
      case (fn)
        6'b100001: return a + b;
        6'b100011: return a - b;
        6'b100100: return a & b;
        6'b100101: return a | b;
        default:   return a ^ b;
      endcase
    end
    return a + b;
  endfunction

  assign alu_Out = alu_fn(alu_opcode, alu_funct, alu_A, alu_B);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = i;
        cnt++;
      end
    end
    if (cnt > 1) return -2;
    return idx;
  endfunction

  // Transaction-level model: one operation in flight, aged in cycles since accept
  bit          m_known    = 1'b0;
  bit          m_inflight = 1'b0;
  int          m_age      = 0;
  int          m_ptr      = 0;
  int          m_grant    = 0;
  logic [5:0]  m_op       = '0;
  logic [5:0]  m_fn       = '0;
  logic [31:0] m_a        = '0;
  logic [31:0] m_b        = '0;
  logic [31:0] m_res      = '0;
  logic [31:0] m_pend     = '0;

  always @(negedge Clock) begin : model_cmp
    logic [N-1:0] e_ready;
    logic [N-1:0] e_valid;
    logic         e_busy;
    int           w;
    w       = rr_pick(req_valid, m_ptr);
    e_ready = '0;
    e_valid = '0;
    e_busy  = 1'b0;
    if (!Reset) begin
      if (!m_inflight) begin
        if (w >= 0) e_ready[w] = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (m_age >= 2) e_valid[m_grant] = 1'b1;
      end
    end
    chk("m_req_ready", 32'(req_ready), 32'(e_ready));
    chk("m_resp_valid", 32'(resp_valid), 32'(e_valid));
    chk("m_busy", 32'(busy), 32'(e_busy));
    if (!Reset && m_known) begin
      chk("m_resp_data", resp_data, m_res);
      chk("m_alu_opcode", 32'(alu_opcode), 32'(m_op));
      chk("m_alu_funct", 32'(alu_funct), 32'(m_fn));
      chk("m_alu_A", alu_A, m_a);
      chk("m_alu_B", alu_B, m_b);
      chk("m_grant_id", 32'(grant_id), 32'(m_grant));
    end
    if (Reset) begin
      m_known = 1'b1; m_inflight = 1'b0; m_ptr = 0; m_grant = 0;
      m_op = '0; m_fn = '0; m_a = '0; m_b = '0; m_res = '0;
    end else if (!m_inflight) begin
      if (w >= 0) begin
        m_inflight = 1'b1;
        m_age      = 1;
        m_grant    = w;
        m_op       = req_opcode[6*w +: 6];
        m_fn       = req_funct[6*w +: 6];
        m_a        = req_A[32*w +: 32];
        m_b        = req_B[32*w +: 32];
        m_pend     = alu_fn(m_op, m_fn, m_a, m_b);
      end
    end else if (m_age == 1) begin
      m_age = 2;
      m_res = m_pend;
    end else if (resp_ready[m_grant]) begin
      m_inflight = 1'b0;
      m_ptr      = (m_grant + 1) % N;
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic probe();
    #3;
  endtask

  task automatic set_req(input int i, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    req_opcode[6*i +: 6] = op;
    req_funct[6*i +: 6]  = fn;
    req_A[32*i +: 32]    = a;
    req_B[32*i +: 32]    = b;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    probe();
    while (busy && n < 10) begin
      cyc();
      probe();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_idx[$];
    int acc_cyc[$];
    int exp_g[5];
    int exp_c[5];
    int w;
    exp_g = '{0, 1, 2, 3, 0};
    exp_c = '{0, 3, 6, 9, 12};

    req_valid  = '1;
    resp_ready = '0;
    req_opcode = '0;
    req_funct  = '0;
    req_A      = '0;
    req_B      = '0;

    // Reset with all requests pending: nothing may be accepted
    probe();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    cyc();
    cyc();
    Reset     = 1'b0;
    req_valid = '0;
    probe();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_alu_A", alu_A, 32'd0);

    // Single op 5+7, operand changed after accept
    cyc();
    set_req(0, 6'b000000, 6'b100001, 32'd5, 32'd7);
    req_valid  = 4'b0001;
    resp_ready = 4'b0001;
    probe();
    chk("t1_accept", 32'(req_ready), 32'h1);
    cyc();
    req_valid    = '0;
    req_A[31:0]  = 32'hFFFF_FFFF;
    probe();
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_valid", 32'(resp_valid), 32'd0);
    chk("t1_alu_A_held", alu_A, 32'd5);
    cyc();
    probe();
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_data", resp_data, 32'h0000_000C);
    cyc();
    probe();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_data_held", resp_data, 32'h0000_000C);

    // All four valid continuously, fair rotation 0,1,2,3,0 every 3 cycles
    cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 6'b000000, 6'b100011, 32'(100 * (i + 1)), 32'(i));
    req_valid  = '1;
    resp_ready = '1;
    for (int c = 0; c < 13; c++) begin
      probe();
      w = onehot_idx(req_ready);
      if (w != -1) begin
        acc_idx.push_back(w);
        acc_cyc.push_back(c);
      end
      cyc();
    end
    req_valid = '0;
    chk("t2_accept_count", 32'(acc_idx.size()), 32'd5);
    for (int k = 0; k < 5 && k < acc_idx.size(); k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(acc_idx[k]), 32'(exp_g[k]));
      chk($sformatf("t2_cycle%0d", k), 32'(acc_cyc[k]), 32'(exp_c[k]));
    end
    wait_idle("t2_idle_timeout");

    // Backpressure on requester 2, other resp_ready bits ignored, then wrap to 0
    cyc();
    set_req(2, 6'b000000, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
    req_valid  = 4'b0100;
    resp_ready = '0;
    probe();
    chk("t3_accept", 32'(req_ready), 32'h4);
    cyc();
    req_valid  = 4'b0011;
    resp_ready = 4'b1011;
    probe();
    chk("t3_exec_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      probe();
      chk("t3_bp_valid", 32'(resp_valid), 32'h4);
      chk("t3_bp_data", resp_data, 32'h00F0_1200);
      chk("t3_bp_busy", 32'(busy), 32'd1);
      chk("t3_bp_ready", 32'(req_ready), 32'd0);
    end
    cyc();
    resp_ready = 4'b0100;
    probe();
    chk("t3_release_valid", 32'(resp_valid), 32'h4);
    cyc();
    resp_ready = '1;
    probe();
    chk("t4_wrap_grant", 32'(req_ready), 32'h1);
    chk("t4_busy", 32'(busy), 32'd0);
    cyc();
    req_valid = '0;
    wait_idle("t4_idle_timeout");

    // Reset while requester 2 is in RESP abandons it
    cyc();
    req_valid  = 4'b0100;
    resp_ready = '0;
    probe();
    chk("t5_accept", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    probe();
    cyc();
    probe();
    chk("t5_resp_valid", 32'(resp_valid), 32'h4);
    cyc();
    Reset = 1'b1;
    probe();
    chk("t5_rst_valid", 32'(resp_valid), 32'd0);
    cyc();
    Reset = 1'b0;
    probe();
    chk("t5_post_valid", 32'(resp_valid), 32'd0);
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_data", resp_data, 32'd0);
    chk("t5_post_grant", 32'(grant_id), 32'd0);
    cyc();
    req_valid  = 4'b1001;
    resp_ready = '1;
    probe();
    chk("t5_ptr_reset", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    wait_idle("t5_idle_timeout");

    // Requester 3 served normally afterwards
    cyc();
    set_req(3, 6'b001000, 6'b000000, 32'h10, 32'h20);
    req_valid  = 4'b1000;
    resp_ready = 4'b1000;
    probe();
    chk("t6_accept", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    probe();
    cyc();
    probe();
    chk("t6_resp_valid", 32'(resp_valid), 32'h8);
    chk("t6_resp_data", resp_data, 32'h30);
    chk("t6_grant_id", 32'(grant_id), 32'd3);
    cyc();
    probe();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
